aibcr3aux_actred_shift_ctl: RTL and testbench
=============================================

AIBCR3AUX_ACTRED_SHIFT_CTL -- requirements
Module: aibcr3aux_actred_shift_ctl

Interface
REQ-001 Parameter NUM_CHAIN, default 2: number of independent active-redundancy chains, range 1..8.
REQ-002 Parameter CHAIN_LEN, default 16: bits per chain, range 2..64.
REQ-003 Parameter DIV, default 4: dig_clk cycles per shift tick, range 1..16.
REQ-004 The block SHALL use one clock, dig_clk; reset dig_rst is synchronous and active-high.
REQ-005 dig_clk  input  1  block clock; all state changes on its rising edge.
REQ-006 dig_rst  input  1  synchronous, active-high reset.
REQ-007 csr_actred_start  input  1  start pulse.
REQ-008 csr_actred_abort  input  1  abort request.
REQ-009 csr_actred_chain_en  input  NUM_CHAIN  per-chain enable, sampled at start.
REQ-010 csr_actred_cfg  input  NUM_CHAIN*CHAIN_LEN  config; chain i occupies bits [i*CHAIN_LEN +: CHAIN_LEN], LSB shifted first.
REQ-011 actred_rx_chain  input  NUM_CHAIN  serial return data from each chain's scan output.
REQ-012 actred_chain  output  NUM_CHAIN  serial data to IO buffer async_dat_in1.
REQ-013 actred_shiften_chain  output  NUM_CHAIN  per-chain shift enable.
REQ-014 actred_busy  output  1  high while in SHIFT.
REQ-015 actred_done  output  1  one-cycle completion pulse.
REQ-016 actred_err  output  NUM_CHAIN  sticky per-chain readback mismatch.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, DONE; IDLE -> SHIFT on start (no abort); SHIFT -> DONE after 2*CHAIN_LEN ticks; DONE -> IDLE after exactly one cycle.
REQ-018 On start accept in IDLE, the block SHALL latch cfg into per-chain circular shift registers, latch chain_en, clear actred_err, and reset the divider and tick counter.
REQ-019 The divider SHALL count 0..DIV-1 in SHIFT; a tick occurs in the cycle where the count equals DIV-1; DIV=1 gives a tick every cycle.
REQ-020 In SHIFT, actred_chain[i] SHALL equal the current LSB of chain i's register; on each tick the register rotates right by one.
REQ-021 actred_shiften_chain[i] SHALL be high for the whole SHIFT state when chain i is enabled, and low otherwise.
REQ-022 Disabled chains SHALL drive actred_chain=0 and shiften=0, and SHALL never set err.
REQ-023 Ticks 0..CHAIN_LEN-1 are fill; during ticks CHAIN_LEN..2*CHAIN_LEN-1, at each tick cycle, the block SHALL compare actred_rx_chain[i] with actred_chain[i] and set err[i] on mismatch.
REQ-024 After 2*CHAIN_LEN ticks, each enabled chain holds cfg, and the register has returned to its latched value.
REQ-025 Timing: with start accepted at edge 0, the SHIFT outputs SHALL appear from cycle 1, the SHIFT state SHALL last 2*CHAIN_LEN*DIV cycles, and done SHALL be high in cycle 2*CHAIN_LEN*DIV+1.
REQ-026 Outside SHIFT, actred_chain and actred_shiften_chain SHALL be 0.
REQ-027 Start while in SHIFT or DONE SHALL be ignored.
REQ-028 Start and abort in the same IDLE cycle: abort wins and the FSM stays in IDLE.
REQ-029 Abort in SHIFT SHALL move the FSM to IDLE at the next edge, deassert shiften at the next edge, leave err unchanged, and produce no done pulse.
REQ-030 Abort in DONE SHALL be ignored, and the done pulse SHALL still complete.

Reset
REQ-031 dig_rst high at an edge SHALL force IDLE and clear the divider, tick counter and shift registers.
REQ-032 Under reset, actred_chain, actred_shiften_chain, actred_busy, actred_done and actred_err SHALL all be 0.
REQ-033 Reset mid-SHIFT SHALL take effect at the next edge with no done pulse; reset has priority over start and abort.

Verification (NUM_CHAIN=2, CHAIN_LEN=16, DIV=4)
REQ-034 Loopback: cfg=0xA5C3_1234, en=2'b11, rx driven as chain output delayed 16 ticks -> busy for 128 cycles, done at cycle 129, err=2'b00, and the first 16 bits on chain0 are 0x1234 LSB-first.
REQ-035 Mismatch: rx[1] stuck at 0 with chain1 cfg=0xA5C3 -> err=2'b10 at done, err persists into IDLE, and the next start clears it.
REQ-036 Partial enable: en=2'b01 -> chain1 data and shiften stay 0 throughout, and err[1]=0 even with rx[1] toggling randomly.
REQ-037 Abort at cycle 50 of SHIFT -> IDLE and shiften=0 at cycle 51, no done pulse, and err retains its pre-abort value.
REQ-038 Edge cases: start+abort in the same cycle -> stays IDLE; start during SHIFT -> ignored, still exactly one done; dig_rst at cycle 70 -> all outputs 0 next cycle.
REQ-039 DIV=1 rerun of REQ-034 -> done at cycle 33, and a tick occurs every cycle.

Source files
------------

// File: rtl/aibcr3aux_actred_shift_ctl.sv
// ----------------------------------------------------------------------------
// aibcr3aux_actred_shift_ctl
//
// Serialises an active-redundancy configuration word into one or more
// independent scan chains. Each chain's data is rotated out LSB-first, one bit
// per shift tick. The word goes round twice. The first pass fills the chain.
// On the second pass the block compares the chain's scan output with the bit
// it is driving at the same time. Any difference sets a sticky per-chain
// error flag.
//
// Parameters
//   NUM_CHAIN  number of independent chains (1..8)
//   CHAIN_LEN  bits per chain (2..64)
//   DIV        dig_clk cycles per shift tick (1..16)
//
// Ports
//   dig_clk               in   block clock, rising-edge
//   dig_rst               in   synchronous active-high reset
//   csr_actred_start      in   start pulse (accepted only in IDLE)
//   csr_actred_abort      in   abort request (wins over start, ends SHIFT)
//   csr_actred_chain_en   in   per-chain enable, latched at start
//   csr_actred_cfg        in   config, chain i at [i*CHAIN_LEN +: CHAIN_LEN]
//   actred_rx_chain       in   serial return data from each chain
//   actred_chain          out  serial data to each chain (0 outside SHIFT)
//   actred_shiften_chain  out  per-chain shift enable (0 outside SHIFT)
//   actred_busy           out  high while shifting
//   actred_done           out  one-cycle completion pulse
//   actred_err            out  sticky per-chain readback mismatch
// ----------------------------------------------------------------------------
module aibcr3aux_actred_shift_ctl #(
    parameter int unsigned NUM_CHAIN = 2,
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned DIV       = 4
) (
    input  logic                           dig_clk,
    input  logic                           dig_rst,
    input  logic                           csr_actred_start,
    input  logic                           csr_actred_abort,
    input  logic [NUM_CHAIN-1:0]           csr_actred_chain_en,
    input  logic [NUM_CHAIN*CHAIN_LEN-1:0] csr_actred_cfg,
    input  logic [NUM_CHAIN-1:0]           actred_rx_chain,
    output logic [NUM_CHAIN-1:0]           actred_chain,
    output logic [NUM_CHAIN-1:0]           actred_shiften_chain,
    output logic                           actred_busy,
    output logic                           actred_done,
    output logic [NUM_CHAIN-1:0]           actred_err
);

    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TICK_W = $clog2(2 * CHAIN_LEN);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(2 * CHAIN_LEN - 1);
    localparam logic [TICK_W-1:0] TICK_CMP0 = TICK_W'(CHAIN_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_reg,    state_next;
    logic [DIV_W-1:0]    div_cnt_reg,  div_cnt_next;
    logic [TICK_W-1:0]   tick_cnt_reg, tick_cnt_next;

    logic start_acc;
    logic tick;
    logic shift_adv;
    logic compare_phase;

    // Abort beats start in IDLE, so a simultaneous pair never launches a run.
    assign start_acc     = (state_reg == ST_IDLE) && csr_actred_start && !csr_actred_abort;
    assign tick          = (state_reg == ST_SHIFT) && (div_cnt_reg == DIV_LAST);
    // An aborting cycle must not rotate data or touch the error flags.
    assign shift_adv     = tick && !csr_actred_abort;
    // Second pass: the chain is full, so its output should echo what we drive.
    assign compare_phase = (tick_cnt_reg >= TICK_CMP0);

    assign actred_busy = (state_reg == ST_SHIFT);
    assign actred_done = (state_reg == ST_DONE);

    // ------------------------------------------------------------------
    // Control FSM and tick/divider counters
    // ------------------------------------------------------------------
    always_ff @(posedge dig_clk) begin
        if (dig_rst) begin
            state_reg    <= ST_IDLE;
            div_cnt_reg  <= '0;
            tick_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            tick_cnt_reg <= tick_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        tick_cnt_next = tick_cnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start_acc) begin
                    state_next    = ST_SHIFT;
                    div_cnt_next  = '0;
                    tick_cnt_next = '0;
                end
            end
            ST_SHIFT: begin
                if (csr_actred_abort) begin
                    state_next    = ST_IDLE;
                    div_cnt_next  = '0;
                    tick_cnt_next = '0;
                end else if (tick) begin
                    div_cnt_next = '0;
                    if (tick_cnt_reg == TICK_LAST) begin
                        state_next    = ST_DONE;
                        tick_cnt_next = '0;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_W'(1);
                end
            end
            ST_DONE: begin
                // Abort is ignored here; the done pulse always completes.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-chain circular shift register, enable latch and sticky error
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CHAIN; gi++) begin : g_chain
            logic [CHAIN_LEN-1:0] sr_reg;
            logic                 en_reg;
            logic                 err_reg;

            always_ff @(posedge dig_clk) begin
                if (dig_rst) begin
                    sr_reg  <= '0;
                    en_reg  <= 1'b0;
                    err_reg <= 1'b0;
                end else if (start_acc) begin
                    sr_reg  <= csr_actred_cfg[gi*CHAIN_LEN +: CHAIN_LEN];
                    en_reg  <= csr_actred_chain_en[gi];
                    err_reg <= 1'b0;
                end else if (shift_adv) begin
                    // Rotate right so the word is back in place after each pass.
                    sr_reg <= {sr_reg[0], sr_reg[CHAIN_LEN-1:1]};
                    if (compare_phase && en_reg && (actred_rx_chain[gi] != sr_reg[0])) begin
                        err_reg <= 1'b1;
                    end
                end
            end

            assign actred_chain[gi]         = actred_busy && en_reg && sr_reg[0];
            assign actred_shiften_chain[gi] = actred_busy && en_reg;
            assign actred_err[gi]           = err_reg;
        end
    endgenerate

endmodule

// File: tb/tb_aibcr3aux_actred_shift_ctl.sv
// ----------------------------------------------------------------------------
// Bench for aibcr3aux_actred_shift_ctl. Two instances are built, one with
// DIV=4 and one with DIV=1. Both get the same stimulus, and `sel` picks which
// one is observed. Expected end-of-run error flags and the first 16 chain0
// bits go into queues when a run is launched, and are taken out when the DUT
// gets to that point. Per-cycle chain data comes from a small model of the
// rotating register.
// ----------------------------------------------------------------------------
module tb_aibcr3aux_actred_shift_ctl;

    localparam int NC = 2;
    localparam int CL = 16;

    logic          dig_clk = 1'b0;
    logic          dig_rst = 1'b1;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic [NC-1:0] chain_en = '0;
    logic [31:0]   cfg      = '0;
    logic [NC-1:0] rx       = '0;

    logic [NC-1:0] chain4, shiften4, err4, chain1, shiften1, err1;
    logic          busy4, done4, busy1, done1;

    bit sel = 1'b0;
    logic [NC-1:0] chain, shiften, err;
    logic          busy, done;

    assign chain   = sel ? chain1   : chain4;
    assign shiften = sel ? shiften1 : shiften4;
    assign err     = sel ? err1     : err4;
    assign busy    = sel ? busy1    : busy4;
    assign done    = sel ? done1    : done4;

    aibcr3aux_actred_shift_ctl #(.NUM_CHAIN(NC), .CHAIN_LEN(CL), .DIV(4)) dut4 (
        .dig_clk              (dig_clk),
        .dig_rst              (dig_rst),
        .csr_actred_start     (start),
        .csr_actred_abort     (abort),
        .csr_actred_chain_en  (chain_en),
        .csr_actred_cfg       (cfg),
        .actred_rx_chain      (rx),
        .actred_chain         (chain4),
        .actred_shiften_chain (shiften4),
        .actred_busy          (busy4),
        .actred_done          (done4),
        .actred_err           (err4)
    );

    aibcr3aux_actred_shift_ctl #(.NUM_CHAIN(NC), .CHAIN_LEN(CL), .DIV(1)) dut1 (
        .dig_clk              (dig_clk),
        .dig_rst              (dig_rst),
        .csr_actred_start     (start),
        .csr_actred_abort     (abort),
        .csr_actred_chain_en  (chain_en),
        .csr_actred_cfg       (cfg),
        .actred_rx_chain      (rx),
        .actred_chain         (chain1),
        .actred_shiften_chain (shiften1),
        .actred_busy          (busy1),
        .actred_done          (done1),
        .actred_err           (err1)
    );

    always #5 dig_clk = ~dig_clk;

    int n_total = 0;
    int n_pass  = 0;

    logic       bitq[$];
    logic [1:0] errq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge dig_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    busy,    0);
        chk({tag, "_done"},    done,    0);
        chk({tag, "_chain"},   chain,   0);
        chk({tag, "_shiften"}, shiften, 0);
    endtask

    // mode 0: loopback on both chains; 1: rx[1] stuck at 0; 2: rx[1] random.
    // abort_at / rst_at / restart_at: SHIFT cycle of that event, 0 = none.
    task automatic run(input string name, input logic [31:0] c, input logic [1:0] en,
                       input int mode, input int abort_at, input int rst_at,
                       input int restart_at, input logic [1:0] exp_err);
        int         div, total, t, b;
        bit         ended;
        logic [15:0] c0, c1;
        logic [1:0] mexp, e;
        logic       qb;
        div   = sel ? 1 : 4;
        total = 2 * CL * div;
        c0    = c[15:0];
        c1    = c[31:16];
        ended = 0;
        for (int k = 0; k < CL; k++) bitq.push_back(c0[k]);
        errq.push_back(exp_err);

        cfg = c; chain_en = en; start = 1'b1;
        step();
        start = 1'b0;
        for (int cy = 1; cy <= total && !ended; cy++) begin
            t = (cy - 1) / div;
            b = t % CL;
            mexp[0] = en[0] & c0[b];
            mexp[1] = en[1] & c1[b];
            chk({name, "_busy"},    busy,    1);
            chk({name, "_done"},    done,    0);
            chk({name, "_shiften"}, shiften, en);
            chk({name, "_chain"},   chain,   mexp);
            if (cy == 1) chk({name, "_errclr"}, err, 0);
            if ((cy % div) == 0 && t < CL) begin
                qb = bitq.pop_front();
                chk({name, "_sb_bit"}, chain[0], qb);
            end
            rx[0] = c0[b];
            case (mode)
                0:       rx[1] = c1[b];
                1:       rx[1] = 1'b0;
                default: rx[1] = 1'($urandom_range(0, 1));
            endcase
            start   = (cy == restart_at);
            abort   = (cy == abort_at);
            dig_rst = (cy == rst_at);
            step();
            start = 1'b0;
            abort = 1'b0;
            if (cy == abort_at) begin
                e = errq.pop_front();
                bitq.delete();
                chk_all_zero({name, "_abort"});
                chk({name, "_abort_err"}, err, e);
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk({name, "_abort_nodone"}, done, 0);
                end
                ended = 1;
            end
            if (cy == rst_at) begin
                void'(errq.pop_front());
                bitq.delete();
                chk_all_zero({name, "_rst"});
                chk({name, "_rst_err"}, err, 0);
                dig_rst = 1'b0;
                step();
                chk({name, "_rst_nodone"}, done, 0);
                ended = 1;
            end
        end
        rx = '0;
        if (!ended) begin
            e = errq.pop_front();
            chk({name, "_done"},        done,    1);
            chk({name, "_done_busy"},   busy,    0);
            chk({name, "_done_shen"},   shiften, 0);
            chk({name, "_done_chain"},  chain,   0);
            chk({name, "_done_err"},    err,     e);
            step();
            chk({name, "_pulse_end"},   done,    0);
            chk({name, "_idle_busy"},   busy,    0);
            chk({name, "_idle_err"},    err,     e);
            chk({name, "_sb_empty"},    bitq.size(), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        dig_rst = 1'b1;
        repeat (3) step();
        chk_all_zero("reset");
        chk("reset_err", err, 0);
        dig_rst = 1'b0;
        step();

        run("loop",    32'hA5C3_1234, 2'b11, 0, 0,   0,  0,  2'b00);
        run("mism",    32'hA5C3_1234, 2'b11, 1, 0,   0,  0,  2'b10);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mism_persist", err, 2'b10);
        end
        run("partial", 32'hA5C3_1234, 2'b01, 2, 0,   0,  0,  2'b00);
        run("abort50", 32'hA5C3_1234, 2'b11, 0, 50,  0,  0,  2'b00);
        run("abort100",32'hA5C3_1234, 2'b11, 1, 100, 0,  0,  2'b10);

        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        step();
        chk("start_abort_busy2", busy, 0);
        chk("start_abort_done", done, 0);

        run("restart", 32'hA5C3_1234, 2'b11, 0, 0,   0,  40, 2'b00);
        run("rst70",   32'hA5C3_1234, 2'b11, 1, 0,   70, 0,  2'b00);

        dig_rst = 1'b1;
        repeat (2) step();
        dig_rst = 1'b0;
        sel = 1'b1;
        step();
        chk_all_zero("div1_idle");
        run("div1",    32'hA5C3_1234, 2'b11, 0, 0,   0,  0,  2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
